// File: rtl/ahb_slave_wr_if.sv
// AHB-Lite write slave front end. It pairs each accepted address phase with
// its data phase and pushes complete write beats, with byte strobes, into a
// command FIFO. It stalls the bus with wait states while the FIFO is full and
// answers unsupported transfers (reads, oversize, misaligned) with a two-cycle
// ERROR response.
// Optional build macro: AHB_SLV_STATS_EN adds the saturating stat_* counters.
module ahb_slave_wr_if #(
  parameter int unsigned AHB_DATA_WIDTH    = 64,
  parameter int unsigned AHB_ADDRESS_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           HSEL,
  input  logic [AHB_ADDRESS_WIDTH-1:0]   HADDR,
  input  logic [AHB_DATA_WIDTH-1:0]      HWDATA,
  input  logic                           HWRITE,
  input  logic [2:0]                     HSIZE,
  input  logic [2:0]                     HBURST,
  input  logic [1:0]                     HTRANS,
  input  logic                           HREADY,
  output logic                           HREADYOUT,
  output logic                           HRESP,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [AHB_ADDRESS_WIDTH-1:0]   cmd_addr,
  output logic [AHB_DATA_WIDTH-1:0]      cmd_data,
  output logic [AHB_DATA_WIDTH/8-1:0]    cmd_strb,
  output logic [2:0]                     cmd_size,
  output logic [2:0]                     cmd_burst,
  output logic                           cmd_first
`ifdef AHB_SLV_STATS_EN
  ,
  output logic [31:0]                    stat_beats,
  output logic [15:0]                    stat_errors,
  output logic [31:0]                    stat_stalls
`endif
);

  localparam int unsigned NB  = AHB_DATA_WIDTH / 8;
  localparam int unsigned LNB = $clog2(NB);
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_e;

  typedef struct packed {
    logic [AHB_ADDRESS_WIDTH-1:0] addr;
    logic [AHB_DATA_WIDTH-1:0]    data;
    logic [NB-1:0]                strb;
    logic [2:0]                   size;
    logic [2:0]                   burst;
    logic                         first;
  } entry_t;

  state_e                       state_q;
  logic                         hresp_q;
  logic                         pend_valid_q;
  logic [AHB_ADDRESS_WIDTH-1:0] pend_addr_q;
  logic [NB-1:0]                pend_strb_q;
  logic [2:0]                   pend_size_q;
  logic [2:0]                   pend_burst_q;
  logic                         pend_first_q;
  entry_t                       mem_q [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                count_q;

  logic [31:0]                  lo_w, hsize_w, nbytes_w;
  logic [AHB_ADDRESS_WIDTH-1:0] amask;
  logic [NB-1:0]                strb_d;
  logic                         accept, err_xfer, good_xfer, bad_xfer;
  logic                         fifo_full, hready_out, push, pop;
  entry_t                       head;

  // Decode the address phase: byte-lane strobe, alignment mask and error checks.
  always_comb begin
    lo_w                = '0;
    lo_w[LNB-1:0]       = HADDR[LNB-1:0];
    hsize_w             = {29'd0, HSIZE};
    nbytes_w            = 32'd1 << HSIZE;
    amask               = '0;
    strb_d              = '0;
    for (int unsigned i = 0; i < AHB_ADDRESS_WIDTH; i++) amask[i] = (i < hsize_w);
    for (int unsigned i = 0; i < NB; i++) strb_d[i] = (i >= lo_w) && (i < lo_w + nbytes_w);
    accept    = HSEL && HREADY && HTRANS[1] && (state_q != ST_ERR1);
    err_xfer  = !HWRITE || (hsize_w > LNB) || (|(HADDR & amask));
    good_xfer = accept && !err_xfer;
    bad_xfer  = accept && err_xfer;
  end

  // Data-phase handshake: stall only when a beat is waiting and the FIFO is full.
  always_comb begin
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    hready_out = (state_q != ST_ERR1) && !(pend_valid_q && fifo_full);
    push       = pend_valid_q && hready_out && HREADY;
    pop        = (count_q != '0) && cmd_ready;
    head       = mem_q[rd_ptr_q];
  end

  assign HREADYOUT = hready_out;
  assign HRESP     = hresp_q;
  assign cmd_valid = (count_q != '0);
  assign cmd_addr  = head.addr;
  assign cmd_data  = head.data;
  assign cmd_strb  = head.strb;
  assign cmd_size  = head.size;
  assign cmd_burst = head.burst;
  assign cmd_first = head.first;

  // Error response FSM; HRESP is registered alongside the state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_OKAY;
      hresp_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_OKAY: begin
          if (bad_xfer) begin
            state_q <= ST_ERR1;
            hresp_q <= 1'b1;
          end
        end
        ST_ERR1: begin
          state_q <= ST_ERR2;
          hresp_q <= 1'b1;
        end
        ST_ERR2: begin
          // A new transfer accepted in the second error cycle may itself be bad.
          if (bad_xfer) begin
            state_q <= ST_ERR1;
            hresp_q <= 1'b1;
          end else begin
            state_q <= ST_OKAY;
            hresp_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_OKAY;
          hresp_q <= 1'b0;
        end
      endcase
    end
  end

  // Pending address-phase register, reloaded by a back-to-back acceptance.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_strb_q  <= '0;
      pend_size_q  <= '0;
      pend_burst_q <= '0;
      pend_first_q <= 1'b0;
    end else if (good_xfer) begin
      pend_valid_q <= 1'b1;
      pend_addr_q  <= HADDR;
      pend_strb_q  <= strb_d;
      pend_size_q  <= HSIZE;
      pend_burst_q <= HBURST;
      pend_first_q <= (HTRANS == 2'b10);
    end else if (push) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Command FIFO storage and pointers; simultaneous push and pop keep the count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{addr: pend_addr_q, data: HWDATA, strb: pend_strb_q,
                            size: pend_size_q, burst: pend_burst_q, first: pend_first_q};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

`ifdef AHB_SLV_STATS_EN
  // Saturating beat / error / stall counters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stat_beats  <= '0;
      stat_errors <= '0;
      stat_stalls <= '0;
    end else begin
      if (push && (stat_beats != '1))                          stat_beats  <= stat_beats + 1'b1;
      if (bad_xfer && (stat_errors != '1))                     stat_errors <= stat_errors + 1'b1;
      if (pend_valid_q && !hready_out && (stat_stalls != '1))  stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: doc/ahb_slave_wr_if.md
Name: ahb_slave_wr_if

Overview:
AHB-Lite slave front end of the bridge. It sits directly downstream of the AHB master stimulus (HADDR/HWDATA/HWRITE/HSIZE/HBURST/HTRANS). It pairs each accepted address phase with its data phase and pushes complete write beats, with byte strobes, into an internal command FIFO. It inserts wait states when the FIFO is full and returns a two-cycle ERROR for unsupported transfers.

Parameters:
AHB_DATA_WIDTH, 64, HWDATA/cmd_data width in bits (power of 2, 32..256)
AHB_ADDRESS_WIDTH, 32, HADDR/cmd_addr width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
HCLK  in  1  bus clock, all logic on rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  AHB_ADDRESS_WIDTH  transfer address
HWDATA  in  AHB_DATA_WIDTH  write data (data phase)
HWRITE  in  1  1=write
HSIZE  in  3  transfer size, bytes = 2**HSIZE
HBURST  in  3  burst type (AHB encoding)
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HREADY  in  1  bus-level ready (previous transfer done)
HREADYOUT  out  1  this slave's ready
HRESP  out  1  0 OKAY, 1 ERROR
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  consumer pops head when cmd_valid & cmd_ready
cmd_addr  out  AHB_ADDRESS_WIDTH  beat address
cmd_data  out  AHB_DATA_WIDTH  raw HWDATA, unmasked
cmd_strb  out  AHB_DATA_WIDTH/8  active byte lanes
cmd_size  out  3  HSIZE of beat
cmd_burst  out  3  HBURST of beat
cmd_first  out  1  beat came from a NONSEQ

Behaviour:
- Reset (async, HRESETn=0): HREADYOUT=1, HRESP=0, cmd_valid=0, FIFO empty, pending register cleared, FSM=OKAY. All other cmd_* outputs are 0.
- Address phase accepted at posedge when HSEL & HREADY & HTRANS[1]. IDLE/BUSY and unselected cycles get zero-wait OKAY with no side effect.
- An accepted transfer is an error if any of the following holds: HWRITE=0; 2**HSIZE > AHB_DATA_WIDTH/8; HADDR not aligned to 2**HSIZE.
- Good transfer: addr, size, burst, first(=HTRANS==10) and strobe are latched into the pending register and pend_valid=1.
- Strobe bits set: lo = HADDR mod (AHB_DATA_WIDTH/8) through lo + 2**HSIZE - 1. All other bits are 0.
- Data phase: HREADYOUT = !(pend_valid & fifo_full), where fifo_full comes from the registered count (no cmd_ready->HREADYOUT combinational path).
- At posedge with pend_valid & HREADYOUT=1: push {pending, HWDATA} into the FIFO, then clear pend_valid, unless a new address phase is accepted in the same cycle, which reloads it.
- FIFO push and pop in the same cycle are legal at any occupancy; count is unchanged.
- A pop while full releases HREADYOUT on the following cycle (one stall cycle minimum). Push never occurs when full.
- cmd_* outputs show the FIFO head. The head is stable while cmd_valid & !cmd_ready.
- Error FSM states: OKAY -> ERR1 on acceptance of an error transfer. ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 next cycle. ERR2 (HREADYOUT=1, HRESP=1) -> OKAY.
- The error transfer's data phase pushes nothing.
- Address phases are not accepted in ERR1 (HREADY=0). In ERR2 a new address phase is accepted normally.
- A BUSY inside a burst does not disturb a pending data phase. A master-cancelled burst after ERROR needs no special handling.
- HREADY=0 driven by another slave: no acceptance, pending data phase is held.

Optional Feature:
AHB_SLV_STATS_EN
- Defined: adds outputs stat_beats (32b, +1 per FIFO push), stat_errors (16b, +1 per ERR1 entry) and stat_stalls (32b, +1 per cycle with pend_valid & !HREADYOUT).
- The counters saturate at their maximum and are cleared by HRESETn.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. INCR4 write, HSIZE=010, start 0x0, cmd_ready=1 -> 4 pushes: addr 0x0/0x4/0x8/0xC, strb 0x0F/0xF0/0x0F/0xF0, cmd_first=1,0,0,0, HREADYOUT always 1.
2. cmd_ready=0, FIFO_DEPTH=4, INCR8 word writes from 0x10 -> 4 pushes, then HREADYOUT=0 on the 5th data phase. Raise cmd_ready -> HREADYOUT=1 exactly one cycle after the first pop, and all 8 beats emerge in order.
3. Read NONSEQ at 0x20 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then OKAY. No push. A NONSEQ write issued in the ERR2 cycle is accepted and pushed.
4. INCR4 with a BUSY between beats 2 and 3 -> still exactly 4 pushes with correct data. IDLE cycles produce no push.
5. Write HSIZE=001 at 0x3 (misaligned) and HSIZE=100 on a 64-bit bus -> ERROR sequence each, FIFO unchanged.
6. HRESETn asserted mid-burst with 2 FIFO entries -> immediately cmd_valid=0, HREADYOUT=1, HRESP=0. After release, a SINGLE write at 0x8 pushes with strb 0x0F (HSIZE=010).
